// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } ctrl_state_t;

  localparam int STALL_CNT_W = 16;

  // Enable vector order {pc, ifid, idex, exmem, memwb}; flush order {ifid, idex, exmem, memwb}.
  localparam logic [4:0] WE_RST     = 5'b00000;
  localparam logic [4:0] WE_ALL     = 5'b11111;
  localparam logic [4:0] WE_MEM_HLD = 5'b00001;
  localparam logic [4:0] WE_LD_USE  = 5'b00111;
  localparam logic [3:0] FLUSH_RST  = 4'b1111;
  localparam logic [3:0] FLUSH_NONE = 4'b0000;
  localparam logic [3:0] FLUSH_WB   = 4'b0001;
  localparam logic [3:0] FLUSH_BR   = 4'b1110;
  localparam logic [3:0] FLUSH_IDEX = 4'b0100;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs, memory handshake and register controls of the pipeline controller
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic [REG_ADDR_W-1:0]  idex_rd;
  logic                   idex_mem_re;
  logic                   exmem_branch;
  logic                   exmem_zero;
  logic                   exmem_mem_re;
  logic                   exmem_mem_we;
  logic                   dmem_ready;
  logic                   pc_we;
  logic                   ifid_we;
  logic                   idex_we;
  logic                   exmem_we;
  logic                   memwb_we;
  logic                   ifid_flush;
  logic                   idex_flush;
  logic                   exmem_flush;
  logic                   memwb_flush;
  logic                   dmem_req;
  logic                   mem_timeout_err;
  logic [STALL_CNT_W-1:0] stall_cycles;

  // master is the controller, slave is the datapath/memory side
  modport master (
    input  id_rs1, id_rs2, idex_rd, idex_mem_re, exmem_branch, exmem_zero,
           exmem_mem_re, exmem_mem_we, dmem_ready,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           dmem_req, mem_timeout_err, stall_cycles
  );

  modport slave (
    output id_rs1, id_rs2, idex_rd, idex_mem_re, exmem_branch, exmem_zero,
           exmem_mem_re, exmem_mem_we, dmem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           dmem_req, mem_timeout_err, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// rtl/pipeline_ctrl_load_use_detect.sv - load-use compare of the EX load destination against ID sources
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  mem_re,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = mem_re && (rd != '0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller with load-use, branch and data-memory wait handling
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int REG_ADDR_W  = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  pipeline_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t            state, state_nxt;
  logic [CNT_W-1:0]       wait_cnt, wait_cnt_nxt;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   err_q;
  logic                   load_use;
  logic                   mem_acc;
  logic                   branch_taken;
  logic [4:0]             we_v;
  logic [3:0]             flush_v;
  logic                   req;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .mem_re (bus.idex_mem_re),
    .rd     (bus.idex_rd),
    .rs1    (bus.id_rs1),
    .rs2    (bus.id_rs2),
    .hazard (load_use)
  );

  assign mem_acc      = bus.exmem_mem_re | bus.exmem_mem_we;
  assign branch_taken = bus.exmem_branch & bus.exmem_zero;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    we_v         = WE_ALL;
    flush_v      = FLUSH_NONE;
    req          = 1'b0;
    case (state)
      RUN: begin
        if (mem_acc && !bus.dmem_ready) begin
          req          = 1'b1;
          we_v         = WE_MEM_HLD;
          flush_v      = FLUSH_WB;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end else if (mem_acc) begin
          req = 1'b1;
        end else if (branch_taken) begin
          flush_v = FLUSH_BR;
        end else if (load_use) begin
          we_v    = WE_LD_USE;
          flush_v = FLUSH_IDEX;
        end
      end
      MEM_WAIT: begin
        req = 1'b1;
        if (bus.dmem_ready) begin
          state_nxt = RUN;
        end else begin
          we_v    = WE_MEM_HLD;
          flush_v = FLUSH_WB;
          // ready on the final permitted wait cycle still wins over the fault
          if (wait_cnt == CNT_LAST) begin
            state_nxt = FAULT;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
      end
      FAULT: begin
        we_v    = WE_RST;
        flush_v = FLUSH_WB;
      end
      default: state_nxt = RUN;
    endcase
    // reset forces the control outputs immediately, not at the next edge
    if (!reset_n) begin
      we_v    = WE_RST;
      flush_v = FLUSH_RST;
      req     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if ((state != FAULT) && !we_v[4] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (state_nxt == FAULT) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.pc_we           = we_v[4];
  assign bus.ifid_we         = we_v[3];
  assign bus.idex_we         = we_v[2];
  assign bus.exmem_we        = we_v[1];
  assign bus.memwb_we        = we_v[0];
  assign bus.ifid_flush      = flush_v[3];
  assign bus.idex_flush      = flush_v[2];
  assign bus.exmem_flush     = flush_v[1];
  assign bus.memwb_flush     = flush_v[0];
  assign bus.dmem_req        = req;
  assign bus.mem_timeout_err = err_q;
  assign bus.stall_cycles    = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl with directed and random stimulus
module tb_pipeline_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.REG_ADDR_W(5)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(TMO), .REG_ADDR_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] idx;
    logic [4:0]  we;
    logic [4:0]  dc;
    logic [3:0]  fl;
    logic        req;
    logic        err;
    logic [15:0] stalls;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // reference: mode 0 running, 1 waiting on memory, 2 faulted
  int m_mode = 0;
  int m_waited = 0;
  int m_stalls = 0;

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic ld, input logic br, input logic zr,
                      input logic mre, input logic mwe, input logic rdy);
    exp_t e;
    bit   acc, lu, can_count;
    reset_n          = rst;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.idex_rd      = rd;
    bus.idex_mem_re  = ld;
    bus.exmem_branch = br;
    bus.exmem_zero   = zr;
    bus.exmem_mem_re = mre;
    bus.exmem_mem_we = mwe;
    bus.dmem_ready   = rdy;

    acc       = mre | mwe;
    lu        = ld && (rd != 0) && ((rd == rs1) || (rd == rs2));
    can_count = (m_mode != 2);
    e.idx     = cyc;
    e.we      = 5'b11111;
    e.dc      = 5'b00000;
    e.fl      = 4'b0000;
    e.req     = 1'b0;
    e.err     = (m_mode == 2);
    e.stalls  = m_stalls[15:0];
    if (!rst) begin
      e.we = 5'b00000; e.fl = 4'b1111; e.err = 1'b0; e.stalls = 16'd0;
      m_mode = 0; m_waited = 0; m_stalls = 0;
    end else begin
      if (m_mode == 2) begin
        e.we = 5'b00000; e.fl = 4'b0001;
      end else if (m_mode == 1) begin
        e.req = 1'b1;
        if (rdy) begin
          m_mode = 0;
        end else begin
          e.we = 5'b00000; e.dc = 5'b00001; e.fl = 4'b0001;
          m_waited++;
          if (m_waited == TMO) m_mode = 2;
        end
      end else if (acc && !rdy) begin
        e.req = 1'b1; e.we = 5'b00000; e.dc = 5'b00001; e.fl = 4'b0001;
        m_mode = 1; m_waited = 0;
      end else if (acc) begin
        e.req = 1'b1;
      end else if (br && zr) begin
        e.fl = 4'b1110;
      end else if (lu) begin
        e.we = 5'b00011; e.dc = 5'b00100; e.fl = 4'b0100;
      end
      if (can_count && !e.we[4] && m_stalls < 65535) m_stalls++;
    end
    sb.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mem_access(input int k);
    for (int i = 0; i <= k; i++)
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (i == k));
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req_v, input int c);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, c, act, req_v);
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] act_we;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act_we = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we};
        chk("we", {11'd0, act_we & ~e.dc}, {11'd0, e.we & ~e.dc}, e.idx);
        chk("flush", {12'd0, bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush},
            {12'd0, e.fl}, e.idx);
        chk("dmem_req", {15'd0, bus.dmem_req}, {15'd0, e.req}, e.idx);
        chk("timeout_err", {15'd0, bus.mem_timeout_err}, {15'd0, e.err}, e.idx);
        chk("stall_cycles", bus.stall_cycles, e.stalls, e.idx);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    mem_access(3);
    idle(1);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    mem_access(4);
    idle(1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    mem_access(0);
    for (int i = 0; i < 3000; i++) begin
      logic rst;
      if (m_mode == 2) rst = ($urandom_range(0, 3) != 0);
      else             rst = ($urandom_range(0, 299) != 0);
      step(rst, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4));
    end
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain cycle=%0d actual=%0d required=0", cyc, sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the write-enable and synchronous-flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and taken branches resolved in MEM, and it sequences a wait-state handshake with data memory, including a timeout fault. It sits beside the datapath, reading the control fields already carried by the ID/EX and EX/MEM registers.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum consecutive MEM_WAIT cycles before FAULT (≥1).
- REG_ADDR_W, 5: register-index width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- idex_rd  in  REG_ADDR_W  destination of the instruction in EX.
- idex_mem_re  in  1  instruction in EX is a load.
- exmem_branch, exmem_zero  in  1  branch in MEM; taken when both are 1.
- exmem_mem_re, exmem_mem_we  in  1  memory access in MEM.
- dmem_ready  in  1  data-memory acknowledge.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1  register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  synchronous clears; flush dominates we inside each register.
- dmem_req  out  1  data-memory request.
- mem_timeout_err  out  1  sticky fault flag.
- stall_cycles  out  16  saturating stall counter.

## Operation
- Registered state:
  - FSM state {RUN, MEM_WAIT, FAULT}.
  - Wait counter, width $clog2(MEM_TIMEOUT+1).
  - stall_cycles.
  - mem_timeout_err.
- All other outputs are combinational from the registered state and the inputs.
- While reset_n=0:
  - State RUN; counters and error flag cleared.
  - All *_we=0, all *_flush=1, dmem_req=0, mem_timeout_err=0, stall_cycles=0.
- mem_acc = exmem_mem_re | exmem_mem_we.
- RUN, priority from highest to lowest:
  1. Memory stall: mem_acc & !dmem_ready.
     - dmem_req=1; pc/ifid/idex/exmem_we=0; memwb_flush=1.
     - Next state MEM_WAIT; wait counter←0.
  2. Zero-wait access: mem_acc & dmem_ready.
     - dmem_req=1; all we=1; no flush.
  3. Taken branch: exmem_branch & exmem_zero.
     - All we=1; ifid_flush, idex_flush, exmem_flush=1.
     - PC loads the branch target via the datapath mux.
  4. Load-use: idex_mem_re & idex_rd≠0 & (idex_rd==id_rs1 | idex_rd==id_rs2).
     - pc_we=0, ifid_we=0, idex_flush=1; exmem/memwb_we=1.
  5. Otherwise: all we=1; all flush=0.
- MEM_WAIT:
  - dmem_req=1; pc/ifid/idex/exmem_we=0; memwb_flush=1.
  - Hazard inputs are ignored; load-use is re-evaluated after release.
  - On dmem_ready: all we=1 and no flush; MEM/WB captures the data; next state RUN.
  - Otherwise: wait counter increments. When the counter equals MEM_TIMEOUT-1 and ready is still absent, next state is FAULT.
- FAULT:
  - All we=0, dmem_req=0, memwb_flush=1, mem_timeout_err=1.
  - Only reset_n exits FAULT.
- stall_cycles increments on every cycle with pc_we=0 in RUN or MEM_WAIT. It saturates at 16'hFFFF and does not count in FAULT.

## Timing
- Hazard decisions are zero-latency combinational. They take effect at the same clock edge the inputs are present.
- Load-use stall lasts exactly 1 cycle. At the next edge the load has moved to EX/MEM and the compare clears.
- Branch flush occupies one cycle.
- Memory latency:
  - Ready asserted k cycles after the access enters MEM (k≥1) gives exactly k stall cycles.
  - k=0 gives no stall.
- Timeout: MEM_TIMEOUT consecutive MEM_WAIT cycles without ready. FAULT is entered at the edge ending the last such cycle.
  - dmem_ready arriving on that same cycle wins: return to RUN, no fault.
- Asynchronous reset mid-MEM_WAIT:
  - Immediately drops dmem_req and forces the reset output values.
  - After release, the first cycle is RUN with the counter at 0.
- A branch and a memory access cannot coexist in EX/MEM. If both are asserted, the memory rule wins.

## Structure
- pipeline_ctrl_pkg holds:
  - ctrl_state_t enum {RUN, MEM_WAIT, FAULT}.
  - STALL_CNT_W = 16.
  - The reset constants for the enable and flush vectors.
- One sub-module, load_use_detect: combinational compare of idex_rd against id_rs1/id_rs2, with the x0 exclusion.
- FSM, wait counter and stall counter stay in the top module.

## Test plan
- Reset held, then released:
  - While held: all we=0, all flush=1, stall_cycles=0.
  - First RUN cycle with idle inputs: all we=1, no flush.
- idex_mem_re=1, idex_rd=5, id_rs2=5 for one cycle:
  - pc_we=0, ifid_we=0, idex_flush=1 for exactly 1 cycle; stall_cycles=1.
- Same stimulus with idex_rd=0:
  - No stall.
- exmem_branch=1, exmem_zero=1:
  - ifid/idex/exmem_flush=1 for one cycle; pc_we=1.
- exmem_mem_re=1 with dmem_ready arriving 3 cycles later:
  - dmem_req high for 4 cycles; 3 stall cycles; memwb_flush high for 3 cycles; back to RUN.
- MEM_TIMEOUT=4 with dmem_ready never asserted:
  - FAULT after 4 MEM_WAIT cycles; mem_timeout_err=1 and held; dmem_req=0.
  - Reset clears the fault.
  - Repeat with ready on the 4th wait cycle: no fault.
